sd_block_buffer: RTL
====================

SD_BLOCK_BUFFER -- requirements
Module: sd_block_buffer

Interface
REQ-001 Parameter BLOCK_BYTES, default 512: data payload bytes per block.
REQ-002 Parameter GAP_TIMEOUT, default 4096: maximum clk cycles allowed between consecutive byte strobes while capturing.
REQ-003 clk  input  1  master clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; arms capture of one read block.
REQ-006 byte_valid  input  1  single-cycle strobe; byte_in is valid this cycle (driven from the SD controller's finished_byte).
REQ-007 byte_in  input  8  received byte (driven from the SD controller's incoming_byte).
REQ-008 block_end  input  1  single-cycle strobe marking the last byte of the block (driven from the SD controller's finished_block).
REQ-009 rd_addr  input  9  consumer read address into the data buffer.
REQ-010 rd_data  output  8  buffer byte at the rd_addr sampled on the previous cycle.
REQ-011 busy  output  1  high while capture is armed and not yet finished.
REQ-012 ready  output  1  high when a block completed with a good token and a matching CRC.
REQ-013 error  output  1  high when the last capture ended in failure.
REQ-014 err_code  output  2  failure cause: 0 none, 1 bad token, 2 CRC mismatch, 3 short block or timeout.
REQ-015 crc_calc  output  16  CRC-16 computed over the data bytes of the last capture.

Function
REQ-016 The block SHALL use the states IDLE, TOKEN, DATA, CRC_HI, CRC_LO and DONE.
REQ-017 IDLE: on start -> TOKEN; clear ready, error, err_code, the byte counter, the CRC accumulator and the gap timer.
REQ-018 TOKEN: the first byte_valid with byte_in==8'hFE -> DATA; any other byte -> DONE with err_code 1.
REQ-019 DATA: each byte_valid writes byte_in to buffer[count], feeds it to the CRC and increments count; the byte at count==BLOCK_BYTES-1 -> CRC_HI.
REQ-020 CRC_HI: byte_valid latches the received CRC[15:8] -> CRC_LO.
REQ-021 CRC_LO: byte_valid latches the received CRC[7:0] -> DONE.
REQ-022 In DONE, ready=1 and err_code=0 if the received CRC equals crc_calc; otherwise error=1 and err_code=2.
REQ-023 CRC SHALL be CRC-16-CCITT: polynomial 0x1021, initial value 0x0000, MSB-first, no final XOR, computed over data bytes only; one byte is folded per byte_valid cycle.
REQ-024 block_end asserted in TOKEN or DATA, or in CRC_HI without byte_valid, SHALL -> DONE with err_code 3.
REQ-025 block_end coincident with the CRC_LO byte SHALL be accepted as the normal end.
REQ-026 The gap timer SHALL count cycles in TOKEN/DATA/CRC_HI/CRC_LO, clear on each byte_valid, and on reaching GAP_TIMEOUT -> DONE with err_code 3.
REQ-027 start in any state SHALL abort the current capture and restart at TOKEN, clearing the same items as REQ-017.
REQ-028 When start and byte_valid occur in the same cycle, start wins and the byte SHALL be discarded.
REQ-029 byte_valid and block_end in IDLE or DONE SHALL be ignored; the buffer and status SHALL hold until the next start.
REQ-030 busy SHALL equal 1 exactly in TOKEN, DATA, CRC_HI and CRC_LO.
REQ-031 ready and error SHALL never be 1 simultaneously.
REQ-032 The buffer SHALL be a BLOCK_BYTES x 8 synchronous RAM with one write port (capture) and one read port (consumer).
REQ-033 The read port SHALL be readable in every state with 1-cycle latency.
REQ-034 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-035 The byte counter SHALL be 10 bits wide and SHALL never write beyond address BLOCK_BYTES-1.

Reset
REQ-036 On rst_n low, the block SHALL immediately enter IDLE.
REQ-037 On rst_n low: busy=0, ready=0, error=0, err_code=0, crc_calc=16'h0000, count=0, gap timer=0, rd_data=8'h00.
REQ-038 Buffer contents SHALL be undefined after reset.
REQ-039 Reset asserted mid-capture SHALL discard the capture without error indication.

Verification
REQ-040 start; 0xFE; 512 x 0xFF; CRC bytes 0x7F,0xA1 with block_end on the last byte -> ready=1, error=0, crc_calc=0x7FA1, every rd_data read = 0xFF.
REQ-041 start; 0xFE; bytes 0x00..0xFF twice; correct CRC -> ready=1; rd_addr=300 yields rd_data=0x2C one cycle later.
REQ-042 start; first byte 0x00 -> error=1, err_code=1, busy=0 on the next cycle; later bytes ignored.
REQ-043 start; 0xFE; 512 x 0x00; CRC bytes 0x12,0x34 -> error=1, err_code=2, crc_calc=0x0000.
REQ-044 start; 0xFE; 100 data bytes; then no strobes for GAP_TIMEOUT cycles -> err_code=3; separately, block_end at data byte 100 -> err_code=3.
REQ-045 rst_n low at data byte 200, then start and a full good block -> ready=1 with no stale error; start coincident with byte_valid -> byte discarded and state TOKEN.

Source files
------------

// File: rtl/sd_block_buffer.sv
// sd_block_buffer
//   Captures one SD read block (start token 0xFE, BLOCK_BYTES of data, a
//   16-bit CRC) from a byte-strobed stream into an internal buffer. A consumer
//   can read that buffer at any time. After the block the module reports
//   whether the received CRC matched the CRC-16-CCITT computed over the data.
//
// Parameters
//   BLOCK_BYTES  data payload bytes per block
//   GAP_TIMEOUT  max clk cycles between byte strobes while capturing
//
// Ports
//   clk         master clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       single-cycle pulse, arms (or re-arms) capture of one block
//   byte_valid  byte_in is valid this cycle
//   byte_in     received byte
//   block_end   strobe marking the last byte of the block
//   rd_addr     consumer read address
//   rd_data     buffer byte at the rd_addr sampled on the previous cycle
//   busy        capture armed and not finished
//   ready       block complete, good token, CRC match
//   error       last capture failed
//   err_code    0 none, 1 bad token, 2 CRC mismatch, 3 short block/timeout
//   crc_calc    CRC-16 over the data bytes of the last capture
module sd_block_buffer #(
   parameter int unsigned BLOCK_BYTES = 512,
   parameter int unsigned GAP_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   input  logic        block_end,
   input  logic [8:0]  rd_addr,
   output logic [7:0]  rd_data,
   output logic        busy,
   output logic        ready,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] crc_calc
);

   localparam int unsigned AW = $clog2(BLOCK_BYTES);
   localparam int unsigned GW = $clog2(GAP_TIMEOUT + 1);
   localparam logic [9:0]    LAST_IDX = 10'(BLOCK_BYTES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      TOKEN,
      DATA,
      CRC_HI,
      CRC_LO,
      DONE
   } state_t;

   state_t        state;
   logic [9:0]    count;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    crc_rx_hi;
   logic [15:0]   crc_acc;
   logic          gap_expired;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    mem [BLOCK_BYTES];

   assign crc_calc = crc_acc;

   // Bit-serial CRC-16-CCITT (0x1021), MSB first, one byte per call.
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic [7:0]  dd;
      logic        fb;
      r  = c;
      dd = d;
      for (int unsigned i = 0; i < 8; i++) begin
         fb = r[15] ^ dd[7];
         r  = {r[14:0], 1'b0};
         dd = {dd[6:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   // A byte is stored only when it is really accepted as data: start and
   // block_end both take priority over the strobe in DATA.
   always_comb begin
      wr_en       = (state == DATA) && byte_valid && !start && !block_end;
      wr_addr     = count[AW-1:0];
      gap_expired = !byte_valid && (gap_cnt == GAP_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         ready     <= 1'b0;
         error     <= 1'b0;
         err_code  <= 2'd0;
         count     <= '0;
         gap_cnt   <= '0;
         crc_rx_hi <= '0;
         crc_acc   <= '0;
      end else if (start) begin
         state    <= TOKEN;
         busy     <= 1'b1;
         ready    <= 1'b0;
         error    <= 1'b0;
         err_code <= 2'd0;
         count    <= '0;
         gap_cnt  <= '0;
         crc_acc  <= '0;
      end else begin
         // busy is high exactly in the capture states, so it gates the timer
         if (busy) gap_cnt <= byte_valid ? '0 : gap_cnt + 1'b1;

         case (state)
            TOKEN: begin
               if (block_end) begin
                  state <= DONE; busy <= 1'b0; error <= 1'b1; err_code <= 2'd3;
               end else if (byte_valid) begin
                  if (byte_in == 8'hFE) begin
                     state <= DATA;
                  end else begin
                     state <= DONE; busy <= 1'b0; error <= 1'b1; err_code <= 2'd1;
                  end
               end else if (gap_expired) begin
                  state <= DONE; busy <= 1'b0; error <= 1'b1; err_code <= 2'd3;
               end
            end

            DATA: begin
               if (block_end) begin
                  state <= DONE; busy <= 1'b0; error <= 1'b1; err_code <= 2'd3;
               end else if (byte_valid) begin
                  crc_acc <= crc16_byte(crc_acc, byte_in);
                  count   <= count + 10'd1;
                  if (count == LAST_IDX) state <= CRC_HI;
               end else if (gap_expired) begin
                  state <= DONE; busy <= 1'b0; error <= 1'b1; err_code <= 2'd3;
               end
            end

            CRC_HI: begin
               if (byte_valid) begin
                  crc_rx_hi <= byte_in;
                  state     <= CRC_LO;
               end else if (block_end || gap_expired) begin
                  state <= DONE; busy <= 1'b0; error <= 1'b1; err_code <= 2'd3;
               end
            end

            CRC_LO: begin
               // block_end alongside this byte is the normal end of block
               if (byte_valid) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  if ({crc_rx_hi, byte_in} == crc_acc) begin
                     ready <= 1'b1;
                  end else begin
                     error    <= 1'b1;
                     err_code <= 2'd2;
                  end
               end else if (gap_expired) begin
                  state <= DONE; busy <= 1'b0; error <= 1'b1; err_code <= 2'd3;
               end
            end

            default: ; // IDLE and DONE hold everything until the next start
         endcase
      end
   end

   // Buffer storage has no reset; contents are undefined after reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= byte_in;
   end

   // Read port: registered, returns pre-write data on a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= 8'h00;
      else        rd_data <= mem[rd_addr[AW-1:0]];
   end

endmodule
